// File: rtl/riscv_pkg.sv
// Shared processor definitions used by the register-file write-back path.
//   NREGS    : number of architectural integer registers
//   XLEN     : integer datapath width
//   REG_AW   : register index width
//   wb_req_t : one pending register-file write (destination + result)
//   wb_src_e : identifies a write-back producer for round-robin priority
package riscv_pkg;

  localparam int NREGS  = 32;
  localparam int XLEN   = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding write-back requests from one producer.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_flush        : empties the FIFO; a push in the same cycle is dropped
//   i_push, i_data : enqueue request (ignored while full)
//   i_pop          : dequeue the head (ignored while empty)
//   o_head         : current head entry (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy status from registered state
//   o_rd_mask      : one bit per register, set when a valid entry targets it
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  wb_req_t                  i_data,
  input  logic                     i_pop,
  output wb_req_t                  o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [NREGS-1:0]         o_rd_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t           r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_do_push;
  logic              w_do_pop;
  logic [PW-1:0]     w_slot;
  logic [NREGS-1:0]  w_mask;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers are PW bits wide, so DEPTH being a power of two makes the
  // natural overflow the modulo-DEPTH wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst && !i_flush) r_mem[r_wptr] <= i_data;
  end

  // Walk the live window starting at the read pointer.
  always_comb begin
    w_mask = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_rptr + PW'(k);
      if (CW'(k) < r_count) w_mask[r_mem[w_slot].rd] = 1'b1;
    end
  end

  assign o_rd_mask = w_mask;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side feeder for the flop-based register file. Buffers ALU and LSU
// results in per-source FIFOs, round-robin arbitrates them onto the single
// registered write port, discards writes to x0 and reports which registers
// still have a write in flight.
// Ports:
//   clk, reset, flush            : clock, sync active-high reset, sync discard
//   alu_valid/ready/rd/data      : ALU result handshake
//   lsu_valid/ready/rd/data      : LSU result handshake
//   rf_wen, rf_waddr, rf_wdata   : registered register-file write port
//   pending                      : bit r set while a write to r is buffered
//                                  or presented on the port (bit 0 always 0)
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter  int N     = NREGS,
  parameter  int W     = XLEN,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [W-1:0]  alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [W-1:0]  lsu_data,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic [N-1:0]  pending
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t           w_alu_req, w_lsu_req;
  wb_req_t           w_alu_head, w_lsu_head, w_win;
  logic              w_alu_full, w_lsu_full;
  logic              w_alu_empty, w_lsu_empty;
  logic [CW-1:0]     w_alu_count, w_lsu_count;
  logic [NREGS-1:0]  w_alu_mask, w_lsu_mask;
  logic              w_alu_push, w_lsu_push;
  logic              w_grant_alu, w_grant_lsu, w_tie;
  logic [N-1:0]      w_pending;

  logic              r_wen;
  logic [AW-1:0]     r_waddr;
  logic [W-1:0]      r_wdata;
  wb_src_e           r_tie_pri;

  assign w_alu_req = '{rd: REG_AW'(alu_rd), data: XLEN'(alu_data)};
  assign w_lsu_req = '{rd: REG_AW'(lsu_rd), data: XLEN'(lsu_data)};

  // Ready depends only on registered occupancy; a pop in the same cycle
  // does not reopen a full FIFO until the edge.
  assign alu_ready = (w_alu_count < CW'(DEPTH));
  assign lsu_ready = (w_lsu_count < CW'(DEPTH));

  // x0 writes complete the handshake but are never stored.
  assign w_alu_push = alu_valid && !w_alu_full && (alu_rd != '0);
  assign w_lsu_push = lsu_valid && !w_lsu_full && (lsu_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_flush   (flush),
    .i_push    (w_alu_push),
    .i_data    (w_alu_req),
    .i_pop     (w_grant_alu),
    .o_head    (w_alu_head),
    .o_full    (w_alu_full),
    .o_empty   (w_alu_empty),
    .o_count   (w_alu_count),
    .o_rd_mask (w_alu_mask)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_flush   (flush),
    .i_push    (w_lsu_push),
    .i_data    (w_lsu_req),
    .i_pop     (w_grant_lsu),
    .o_head    (w_lsu_head),
    .o_full    (w_lsu_full),
    .o_empty   (w_lsu_empty),
    .o_count   (w_lsu_count),
    .o_rd_mask (w_lsu_mask)
  );

  // Priority only matters when both heads are present; a lone source
  // always wins and leaves the priority untouched.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_lsu = 1'b0;
    w_tie       = 1'b0;
    if (!flush) begin
      if (!w_alu_empty && !w_lsu_empty) begin
        w_tie = 1'b1;
        if (r_tie_pri == SRC_LSU) w_grant_lsu = 1'b1;
        else                      w_grant_alu = 1'b1;
      end else if (!w_alu_empty) begin
        w_grant_alu = 1'b1;
      end else if (!w_lsu_empty) begin
        w_grant_lsu = 1'b1;
      end
    end
  end

  assign w_win = w_grant_lsu ? w_lsu_head : w_alu_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_tie_pri <= SRC_ALU;
    end else begin
      r_wen <= w_grant_alu || w_grant_lsu;
      if (w_grant_alu || w_grant_lsu) begin
        r_waddr <= AW'(w_win.rd);
        r_wdata <= W'(w_win.data);
      end
      if (w_tie) r_tie_pri <= (r_tie_pri == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  always_comb begin
    w_pending = N'(w_alu_mask | w_lsu_mask);
    if (r_wen) w_pending[r_waddr] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign pending = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import riscv_pkg::*;

  localparam int N     = 32;
  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [W-1:0]  alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [W-1:0]  lsu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic [N-1:0]  pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pending   (pending)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues, a "who wins the next tie" flag and
  // the contents of the write port, advanced once per clock edge.
  wb_req_t        qa[$];
  wb_req_t        ql[$];
  wb_req_t        exp_q[$];
  bit             m_wen     = 1'b0;
  logic [AW-1:0]  m_waddr   = '0;
  logic [W-1:0]   m_wdata   = '0;
  bit             m_pri_alu = 1'b1;
  bit             m_a_acc   = 1'b1;
  bit             m_l_acc   = 1'b1;
  bit             mon_en    = 1'b0;

  always @(posedge clk) begin : model
    bit      a_ne, l_ne;
    wb_req_t w;
    if (reset) begin
      qa.delete();
      ql.delete();
      m_wen     = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
      m_pri_alu = 1'b1;
      m_a_acc   = 1'b1;
      m_l_acc   = 1'b1;
    end else begin
      m_a_acc = alu_valid && (qa.size() < DEPTH);
      m_l_acc = lsu_valid && (ql.size() < DEPTH);
      a_ne    = qa.size() > 0;
      l_ne    = ql.size() > 0;
      m_wen   = 1'b0;
      if (flush) begin
        qa.delete();
        ql.delete();
      end else begin
        if (a_ne && l_ne) begin
          w = m_pri_alu ? qa.pop_front() : ql.pop_front();
          m_pri_alu = !m_pri_alu;
          m_wen = 1'b1;
        end else if (a_ne) begin
          w = qa.pop_front();
          m_wen = 1'b1;
        end else if (l_ne) begin
          w = ql.pop_front();
          m_wen = 1'b1;
        end
        if (m_wen) begin
          m_waddr = w.rd;
          m_wdata = w.data;
          exp_q.push_back(w);
        end
        if (m_a_acc && alu_rd != 0) qa.push_back(wb_req_t'{rd: alu_rd, data: alu_data});
        if (m_l_acc && lsu_rd != 0) ql.push_back(wb_req_t'{rd: lsu_rd, data: lsu_data});
      end
    end
  end

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] p;
    p = '0;
    foreach (qa[i]) p[qa[i].rd] = 1'b1;
    foreach (ql[i]) p[ql[i].rd] = 1'b1;
    if (m_wen) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard whenever the
  // DUT presents a write.
  always @(negedge clk) begin : monitor
    wb_req_t e;
    if (mon_en) begin
      chk("alu_ready", alu_ready, qa.size() < DEPTH);
      chk("lsu_ready", lsu_ready, ql.size() < DEPTH);
      chk("pending", pending, model_pending());
      chk("rf_wen", rf_wen, m_wen);
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", rf_waddr, e.rd);
          chk("wb_data", rf_wdata, e.data);
        end
      end else begin
        chk("idle_waddr", rf_waddr, m_waddr);
        chk("idle_wdata", rf_wdata, m_wdata);
      end
    end
  end

  // Applies one cycle of stimulus; a producer still waiting for ready
  // keeps its previous request unchanged.
  task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [W-1:0] ad,
                       input bit lv, input logic [AW-1:0] lrd, input logic [W-1:0] ld,
                       input bit fl, input bit rs);
    if (!(alu_valid && !m_a_acc)) begin
      alu_valid = av; alu_rd = ard; alu_data = ad;
    end
    if (!(lsu_valid && !m_l_acc)) begin
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    end
    flush = fl;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single uncontended ALU write.
    drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, 0);
    idle(4);

    // Both producers streaming together.
    for (int i = 0; i < 4; i++)
      drive(1, 5'd3, 32'hA000_0000 + i, 1, 5'd7, 32'hB000_0000 + i, 0, 0);
    idle(6);

    // Write to x0 is swallowed.
    drive(1, 5'd0, 32'h0000_1234, 0, '0, '0, 0, 0);
    idle(3);

    // Sustained LSU pressure alongside the ALU.
    for (int i = 0; i < 6; i++)
      drive(1, 5'd9, 32'hC000_0000 + i, 1, 5'd11, 32'hD000_0000 + i, 0, 0);
    idle(8);

    // Flush with buffered entries and a live ALU handshake.
    for (int i = 0; i < 3; i++)
      drive(1, 5'd12, 32'hE000_0000 + i, 1, 5'd13, 32'hF000_0000 + i, 0, 0);
    drive(1, 5'd14, 32'h1111_1111, 0, '0, '0, 1, 0);
    idle(4);

    // Reset in the middle of traffic, then a fresh tie.
    for (int i = 0; i < 3; i++)
      drive(1, 5'd20, 32'h2000_0000 + i, 1, 5'd21, 32'h2100_0000 + i, 0, 0);
    drive(1, 5'd22, 32'h2200_0000, 1, 5'd23, 32'h2300_0000, 0, 1);
    drive(1, 5'd24, 32'h2400_0000, 1, 5'd25, 32'h2500_0000, 0, 0);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ra, rl;
      ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rl = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive($urandom_range(0, 3) != 0, ra, $urandom,
            $urandom_range(0, 3) != 0, rl, $urandom,
            $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end
    idle(10);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
